// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma datapath: bit mapping, CIC sizing helpers and the
// saturating output shift.
package dsm_pkg;

  // Widest accumulator the CIC can need (CIC_ORDER 4, DECIM_LOG2 8).
  localparam int unsigned MaxAccWidth = 34;

  // Bit-to-level mapping, also used by the DAC feedback path.
  localparam logic signed [1:0] BitPos = 2'sb01;
  localparam logic signed [1:0] BitNeg = 2'sb11;

  function automatic int unsigned cic_acc_width(input int unsigned order,
                                                input int unsigned dlog2);
    return order * dlog2 + 2;
  endfunction

  function automatic int unsigned cic_shift(input int unsigned order,
                                            input int unsigned dlog2,
                                            input int unsigned out_w);
    return order * dlog2 + 1 - out_w;
  endfunction

  // Arithmetic right shift, then clamp to an out_w-bit signed range.
  function automatic logic signed [MaxAccWidth-1:0] sat_shift(
      input logic signed [MaxAccWidth-1:0] y,
      input int unsigned                   shift,
      input int unsigned                   out_w);
    logic signed [MaxAccWidth-1:0] s;
    logic signed [MaxAccWidth-1:0] hi;
    logic signed [MaxAccWidth-1:0] lo;
    s = y >>> shift;
    hi = '0;
    hi[out_w-1] = 1'b1;
    hi = hi - MaxAccWidth'(1);
    lo = ~hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: an enabled, freely wrapping two's-complement accumulator.
module cic_integrator_stage #(
  parameter int unsigned Width = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic signed [Width-1:0] i_data,
  output logic signed [Width-1:0] o_next,
  output logic signed [Width-1:0] o_data
);

  logic signed [Width-1:0] acc_q;

  // Wrap-around is intentional; the comb chain cancels it.
  assign o_next = acc_q + i_data;
  assign o_data = acc_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q <= '0;
    end else if (i_en) begin
      acc_q <= o_next;
    end
  end

endmodule

// File: rtl/dsm_cic_decimator.sv
// sinc^N decimator recovering signed samples from a strobed 1-bit delta-sigma stream.
module dsm_cic_decimator
  import dsm_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = 4,
  parameter int unsigned DECIM_LOG2 = 4,
  parameter int unsigned CIC_ORDER  = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_sample,
  input  logic                        i_bit,
  output logic                        o_valid,
  output logic signed [OUT_WIDTH-1:0] o_data
);

  localparam int unsigned AccWidth = cic_acc_width(CIC_ORDER, DECIM_LOG2);
  localparam int unsigned Shift    = cic_shift(CIC_ORDER, DECIM_LOG2, OUT_WIDTH);

  typedef logic signed [AccWidth-1:0] acc_t;

  logic signed [1:0] bit_val;
  acc_t              x;
  acc_t              stage_in [CIC_ORDER];
  acc_t              int_next [CIC_ORDER];

  assign bit_val = i_bit ? BitPos : BitNeg;
  assign x       = AccWidth'(bit_val);

  // Stage k integrates the already-updated output of stage k-1 within the same edge.
  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_int
    if (k == 0) begin : g_first
      assign stage_in[k] = x;
    end else begin : g_rest
      assign stage_in[k] = int_next[k-1];
    end

    cic_integrator_stage #(
      .Width(AccWidth)
    ) u_int (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (i_sample),
      .i_data(stage_in[k]),
      .o_next(int_next[k]),
      .o_data()
    );
  end

  logic [DECIM_LOG2-1:0]        phase_q;
  logic [2:0]                   warm_q;
  logic                         valid_q;
  logic signed [OUT_WIDTH-1:0]  data_q;
  acc_t                         dly_q   [CIC_ORDER];
  acc_t                         comb_in [CIC_ORDER];
  acc_t                         comb_v;
  logic signed [MaxAccWidth-1:0] y_ext;
  logic signed [MaxAccWidth-1:0] sat_w;
  logic                         decim;

  assign decim = i_sample && (phase_q == '1);

  always_comb begin
    comb_v = int_next[CIC_ORDER-1];
    for (int k = 0; k < CIC_ORDER; k++) begin
      comb_in[k] = comb_v;
      comb_v     = comb_v - dly_q[k];
    end
    y_ext = MaxAccWidth'(comb_v);
    sat_w = sat_shift(y_ext, Shift, OUT_WIDTH);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q <= '0;
      warm_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      for (int k = 0; k < CIC_ORDER; k++) dly_q[k] <= '0;
    end else begin
      valid_q <= 1'b0;
      if (i_sample) phase_q <= phase_q + DECIM_LOG2'(1);
      if (decim) begin
        for (int k = 0; k < CIC_ORDER; k++) dly_q[k] <= comb_in[k];
        // Comb delay lines hold garbage until CIC_ORDER frames have passed through.
        if (warm_q < 3'(CIC_ORDER)) begin
          warm_q <= warm_q + 3'd1;
        end else begin
          valid_q <= 1'b1;
          data_q  <= sat_w[OUT_WIDTH-1:0];
        end
      end
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Randomised bench for dsm_cic_decimator against an exact running-sum / finite-difference model.
module tb_dsm_cic_decimator;

  localparam int unsigned OUT_WIDTH  = 4;
  localparam int unsigned DECIM_LOG2 = 4;
  localparam int unsigned CIC_ORDER  = 2;
  localparam int          R          = 1 << DECIM_LOG2;
  localparam int          SHIFT      = CIC_ORDER * DECIM_LOG2 + 1 - OUT_WIDTH;
  localparam longint      OMAX       = (64'sd1 <<< (OUT_WIDTH - 1)) - 1;
  localparam longint      OMIN       = -(64'sd1 <<< (OUT_WIDTH - 1));

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        sample;
  logic                        bitv;
  logic                        valid;
  logic signed [OUT_WIDTH-1:0] data;

  always #5 clk = ~clk;

  dsm_cic_decimator #(
    .OUT_WIDTH (OUT_WIDTH),
    .DECIM_LOG2(DECIM_LOG2),
    .CIC_ORDER (CIC_ORDER)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_sample(sample),
    .i_bit   (bitv),
    .o_valid (valid),
    .o_data  (data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: exact (unbounded) cascaded running sums; the decimated value is the
  // N-th finite difference of the last sum sampled every R accepted bits.
  longint sums [CIC_ORDER];
  longint hist [$];
  int     nbits;
  int     ndec;
  int     first_bits;
  logic   exp_valid;
  longint exp_data;

  function automatic longint nth_diff();
    longint w [$];
    for (int i = 0; i < CIC_ORDER + 1 - hist.size(); i++) w.push_back(0);
    foreach (hist[i]) w.push_back(hist[i]);
    for (int p = 0; p < CIC_ORDER; p++)
      for (int i = CIC_ORDER; i > p; i--) w[i] = w[i] - w[i-1];
    return w[CIC_ORDER];
  endfunction

  function automatic longint clamp_shift(input longint y);
    longint s;
    s = y >>> SHIFT;
    if (s > OMAX) return OMAX;
    if (s < OMIN) return OMIN;
    return s;
  endfunction

  task automatic model_reset();
    foreach (sums[k]) sums[k] = 0;
    hist.delete();
    nbits      = 0;
    ndec       = 0;
    first_bits = -1;
    exp_valid  = 1'b0;
    exp_data   = 0;
  endtask

  task automatic model_edge(input logic s, input logic b);
    exp_valid = 1'b0;
    if (s) begin
      sums[0] += b ? 1 : -1;
      for (int k = 1; k < CIC_ORDER; k++) sums[k] += sums[k-1];
      nbits++;
      if (nbits % R == 0) begin
        hist.push_back(sums[CIC_ORDER-1]);
        if (hist.size() > CIC_ORDER + 1) void'(hist.pop_front());
        ndec++;
        if (ndec > CIC_ORDER) begin
          exp_valid = 1'b1;
          exp_data  = clamp_shift(nth_diff());
        end
      end
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic s, input logic b);
    sample = s;
    bitv   = b;
    @(posedge clk);
    model_edge(s, b);
    #1;
    check_eq("valid", valid, exp_valid);
    check_eq("data", data, exp_data);
    if (valid && first_bits < 0) first_bits = nbits;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    sample = 1'b0;
    #1;
    check_eq("rst_valid", valid, 0);
    check_eq("rst_data", data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // kind: 0 ones, 1 zeros, 2 1010.., 3 1110.., 4 random bits; density = % of strobed cycles
  task automatic run(input int kind, input int nacc, input int density);
    int got;
    int budget;
    logic b;
    logic s;
    got    = 0;
    budget = nacc * 100 + 1000;
    while (got < nacc && budget > 0) begin
      budget--;
      s = ($urandom_range(99) < density);
      case (kind)
        0:       b = 1'b1;
        1:       b = 1'b0;
        2:       b = (nbits % 2 == 0);
        3:       b = (nbits % 4 != 3);
        default: b = 1'($urandom);
      endcase
      step(s, b);
      if (s) got++;
    end
    if (got < nacc) check_eq("run_bound", got, nacc);
    sample = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    sample = 1'b0;
    bitv   = 1'b0;
    model_reset();
    #1;
    check_eq("init_valid", valid, 0);
    check_eq("init_data", data, 0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 160, 100);
    check_eq("ones_first", first_bits, 48);
    check_eq("ones_data", data, 7);

    do_reset();
    run(1, 160, 100);
    check_eq("zeros_data", data, -8);

    do_reset();
    run(2, 160, 100);
    check_eq("alt_data", data, 0);

    do_reset();
    run(3, 160, 100);
    check_eq("p1110_data", data, 4);

    do_reset();
    run(3, 320, 30);
    check_eq("gap_first", first_bits, 48);
    check_eq("gap_data", data, 4);

    // Reset in mid-frame at phase 7.
    do_reset();
    run(3, 4 * R + 7, 100);
    check_eq("mid_pre_data", data, 4);
    @(posedge clk);
    #2;
    do_reset();
    run(3, 100, 100);
    check_eq("mid_first", first_bits, 48);

    do_reset();
    run(4, 2000, 60);

    // Long run: integrators wrap many times.
    do_reset();
    run(3, 40000, 100);
    check_eq("long_data", data, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
